// File: rtl/multimode_ring_counter_pkg.sv
// Shared types for the multimode ring/Johnson counter: counting mode and shift direction.
package multimode_ring_counter_pkg;

  typedef enum logic {
    MODE_RING    = 1'b0,
    MODE_JOHNSON = 1'b1
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

endpackage

// File: rtl/multimode_ring_counter_if.sv
// Control/status bundle for multimode_ring_counter; master drives controls, slave returns state.
interface multimode_ring_counter_if #(
  parameter int N = 4
);
  import multimode_ring_counter_pkg::*;

  logic         en;
  mode_t        mode;
  dir_t         dir;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] q;
  logic         wrap;
  logic         illegal;

  modport master (
    output en, mode, dir, load, load_val,
    input  q, wrap, illegal
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output q, wrap, illegal
  );

endinterface

// File: rtl/multimode_ring_counter_check.sv
// Combinational legality check of a counter code against the selected mode.
module ring_code_check
  import multimode_ring_counter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] code,
  input  mode_t        mode,
  output logic         illegal
);

  logic [N-1:0] code_inv;
  logic         one_hot;
  logic         low_fill;
  logic         high_fill;

  assign code_inv = ~code;

  // x & (x+1) == 0 holds exactly for 0..0 followed by a run of ones from bit 0.
  assign one_hot   = (code != '0) && ((code & (code - N'(1))) == '0);
  assign low_fill  = ((code & (code + N'(1))) == '0);
  assign high_fill = ((code_inv & (code_inv + N'(1))) == '0);

  assign illegal = (mode == MODE_JOHNSON) ? !(low_fill || high_fill) : !one_hot;

endmodule

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson counter with up/down stepping, parallel load and self-correction of illegal codes.
module multimode_ring_counter
  import multimode_ring_counter_pkg::*;
#(
  parameter int N = 4
) (
  input logic                    clk,
  input logic                    rst,
  multimode_ring_counter_if.slave bus
);

  logic [N-1:0] q_r;
  logic [N-1:0] q_next;
  logic [N-1:0] seed;
  logic [N-1:0] step;
  logic         wrap_r;
  logic         wrap_next;
  logic         illegal;

  if (N < 2) begin : g_n_check
    $error("multimode_ring_counter: N must be at least 2");
  end

  ring_code_check #(.N(N)) u_check (
    .code    (q_r),
    .mode    (bus.mode),
    .illegal (illegal)
  );

  always_comb begin
    seed = (bus.mode == MODE_JOHNSON) ? '0 : N'(1);
    step = q_r;
    if (bus.mode == MODE_RING) begin
      if (bus.dir == DIR_UP) step = {q_r[N-2:0], q_r[N-1]};
      else                   step = {q_r[0], q_r[N-1:1]};
    end else begin
      if (bus.dir == DIR_UP) step = {q_r[N-2:0], ~q_r[N-1]};
      else                   step = {~q_r[0], q_r[N-1:1]};
    end
  end

  // Load beats everything; an enabled edge on an illegal code snaps back to the seed silently.
  always_comb begin
    q_next    = q_r;
    wrap_next = 1'b0;
    if (bus.load) begin
      q_next = bus.load_val;
    end else if (bus.en && illegal) begin
      q_next = seed;
    end else if (bus.en) begin
      q_next    = step;
      wrap_next = (step == seed);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= N'(1);
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      wrap_r <= wrap_next;
    end
  end

  assign bus.q       = q_r;
  assign bus.wrap    = wrap_r;
  assign bus.illegal = illegal;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Directed and randomized bench for multimode_ring_counter with a position-based reference model.
module tb_multimode_ring_counter;
  import multimode_ring_counter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multimode_ring_counter_if #(.N(N)) bus ();

  multimode_ring_counter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: a legal code is identified by its position in the mode's cycle.
  function automatic logic [N-1:0] code_at(input logic johnson, input int p);
    if (!johnson) return N'(1) << p;
    if (p <= N)   return N'((1 << p) - 1);
    return N'(((1 << N) - 1) & ~((1 << (p - N)) - 1));
  endfunction

  function automatic int index_of(input logic johnson, input logic [N-1:0] code);
    int period;
    period = johnson ? 2 * N : N;
    for (int p = 0; p < period; p++)
      if (code_at(johnson, p) == code) return p;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_next(input logic [N-1:0] cur, input logic johnson,
                                              input logic down, input logic en, input logic ld,
                                              input logic [N-1:0] lv, output logic wr);
    int idx;
    int period;
    int ni;
    wr = 1'b0;
    if (ld)  return lv;
    if (!en) return cur;
    idx = index_of(johnson, cur);
    if (idx < 0) return code_at(johnson, 0);
    period = johnson ? 2 * N : N;
    ni = down ? (idx + period - 1) % period : (idx + 1) % period;
    wr = (ni == 0);
    return code_at(johnson, ni);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.mode = MODE_RING; bus.dir = DIR_UP;
    #12;
    checks++;
    if (bus.q !== 4'b0001) begin errors++; $display("FAIL reset_q: got %b want 0001", bus.q); end
    checks++;
    if (bus.wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", bus.wrap); end
    checks++;
    if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal_ring: got %b want 0", bus.illegal); end
    bus.mode = MODE_JOHNSON;
    #1;
    checks++;
    if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal_johnson: got %b want 0", bus.illegal); end
    bus.mode = MODE_RING;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ring_up();
    logic [N-1:0] exp_q [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic         exp_w [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bus.mode = MODE_RING; bus.dir = DIR_UP; bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.q !== exp_q[i] || bus.wrap !== exp_w[i]) begin
        errors++;
        $display("FAIL ring_up[%0d]: got q=%b wrap=%b want q=%b wrap=%b", i, bus.q, bus.wrap, exp_q[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_johnson_up();
    logic [N-1:0] exp_q [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    bus.mode = MODE_JOHNSON; bus.dir = DIR_UP; bus.en = 1'b1;
    bus.load = 1'b1; bus.load_val = 4'b0000;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.q !== 4'b0000 || bus.wrap !== 1'b0) begin
      errors++; $display("FAIL johnson_load: got q=%b wrap=%b want q=0000 wrap=0", bus.q, bus.wrap);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.q !== exp_q[i] || bus.wrap !== (i == 7)) begin
        errors++;
        $display("FAIL johnson_up[%0d]: got q=%b wrap=%b want q=%b wrap=%b", i, bus.q, bus.wrap, exp_q[i], (i == 7));
      end
    end
  endtask

  task automatic test_ring_down();
    logic [N-1:0] exp_q [2] = '{4'b1000, 4'b0100};
    bus.en = 1'b0;
    apply_reset();
    bus.mode = MODE_RING; bus.dir = DIR_DOWN; bus.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.q !== exp_q[i] || bus.wrap !== 1'b0) begin
        errors++;
        $display("FAIL ring_down[%0d]: got q=%b wrap=%b want q=%b wrap=0", i, bus.q, bus.wrap, exp_q[i]);
      end
    end
  endtask

  task automatic test_load_illegal();
    bus.mode = MODE_RING; bus.dir = DIR_UP; bus.en = 1'b0;
    bus.load = 1'b1; bus.load_val = 4'b0101;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.q !== 4'b0101 || bus.illegal !== 1'b1) begin
      errors++; $display("FAIL load_illegal: got q=%b illegal=%b want q=0101 illegal=1", bus.q, bus.illegal);
    end
    bus.en = 1'b1;
    tick();
    checks++;
    if (bus.q !== 4'b0001 || bus.illegal !== 1'b0 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL self_correct: got q=%b illegal=%b wrap=%b want q=0001 illegal=0 wrap=0", bus.q, bus.illegal, bus.wrap);
    end
  endtask

  task automatic test_hold_load();
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.q !== 4'b0001 || bus.wrap !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got q=%b wrap=%b want q=0001 wrap=0", i, bus.q, bus.wrap);
      end
    end
    bus.load = 1'b1; bus.load_val = 4'b0100;
    tick();
    bus.load = 1'b0;
    checks++;
    if (bus.q !== 4'b0100) begin errors++; $display("FAIL load_no_en: got %b want 0100", bus.q); end
  endtask

  task automatic test_async_reset();
    bus.en = 1'b1; bus.mode = MODE_RING; bus.dir = DIR_UP;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.q !== 4'b0001 || bus.wrap !== 1'b0) begin
      errors++; $display("FAIL async_reset: got q=%b wrap=%b want q=0001 wrap=0", bus.q, bus.wrap);
    end
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if (bus.q !== 4'b0010) begin errors++; $display("FAIL resume_after_reset: got %b want 0010", bus.q); end
  endtask

  task automatic test_legality();
    bus.en = 1'b0;
    for (int m = 0; m < 2; m++) begin
      bus.mode = (m == 1) ? MODE_JOHNSON : MODE_RING;
      for (int v = 0; v < (1 << N); v++) begin
        bus.load = 1'b1; bus.load_val = N'(v);
        tick();
        checks++;
        if (bus.q !== N'(v) || bus.illegal !== (index_of(m == 1, N'(v)) < 0)) begin
          errors++;
          $display("FAIL legality mode=%0d code=%b: got q=%b illegal=%b want illegal=%b", m, N'(v), bus.q,
                   bus.illegal, (index_of(m == 1, N'(v)) < 0));
        end
      end
    end
    bus.load = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] model_q;
    logic         model_w;
    logic         johnson;
    model_q = bus.q;
    bus.load = 1'b1; bus.load_val = N'($urandom_range(0, (1 << N) - 1));
    for (int i = 0; i < 400; i++) begin
      johnson = (bus.mode == MODE_JOHNSON);
      model_q = model_next(model_q, johnson, bus.dir == DIR_DOWN, bus.en, bus.load, bus.load_val, model_w);
      tick();
      checks++;
      if (bus.q !== model_q || bus.wrap !== model_w || bus.illegal !== (index_of(johnson, model_q) < 0)) begin
        errors++;
        $display("FAIL random[%0d]: got q=%b wrap=%b illegal=%b want q=%b wrap=%b illegal=%b", i, bus.q,
                 bus.wrap, bus.illegal, model_q, model_w, (index_of(johnson, model_q) < 0));
      end
      bus.load     = ($urandom_range(0, 9) == 0);
      bus.load_val = N'($urandom_range(0, (1 << N) - 1));
      bus.en       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) bus.mode = (bus.mode == MODE_RING) ? MODE_JOHNSON : MODE_RING;
      if ($urandom_range(0, 7) == 0)  bus.dir  = (bus.dir == DIR_UP) ? DIR_DOWN : DIR_UP;
    end
    bus.load = 1'b0;
    bus.en   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ring_up();
    test_johnson_up();
    test_ring_down();
    test_load_illegal();
    test_hold_load();
    test_async_reset();
    test_legality();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multimode_ring_counter.md
MULTIMODE_RING_COUNTER -- requirements
Module: multimode_ring_counter

Interface
REQ-001 Parameter N, default 4, is the counter width in bits; legal range N >= 2.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  step enable; 1 = advance one state this cycle.
REQ-005 mode  input  1  0 = ring (one-hot rotate), 1 = Johnson (twisted ring).
REQ-006 dir  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB).
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  N  value captured when load = 1.
REQ-009 q  output  N  registered counter state.
REQ-010 wrap  output  1  registered one-cycle pulse; q has just returned to the seed of the current mode by a normal step.
REQ-011 illegal  output  1  combinational from q and mode; 1 when q is not a legal code for the current mode.

Function
REQ-012 Seeds: ring = 0...01; Johnson = 0...0.
REQ-013 Ring legal codes: exactly one bit set.
REQ-014 Johnson legal codes: all-zero; ones contiguous from bit 0 (0..01 to 1..1); or ones contiguous down from bit N-1 (1..10 to 10..0). This gives 2N codes in total.
REQ-015 Ring up: q[0] <= q[N-1], q[i] <= q[i-1].
REQ-016 Ring down: q[N-1] <= q[0], q[i] <= q[i+1].
REQ-017 Johnson up: q[0] <= ~q[N-1], q[i] <= q[i-1].
REQ-018 Johnson down: q[N-1] <= ~q[0], q[i] <= q[i+1].
REQ-019 Per-edge priority:
- load = 1: q <= load_val unchanged, even if illegal. Overrides en.
- else en = 1 and illegal = 1: q <= seed of the current mode (self-correction).
- else en = 1: the step from REQ-015 to REQ-018.
- else: hold.
REQ-020 wrap <= 1 only when a normal step (REQ-019, third case) produces the seed; otherwise wrap <= 0. Load and self-correction never assert wrap.
REQ-021 Mode or dir changes take effect on the next enabled edge with no latency. A code that becomes illegal under a new mode is corrected by REQ-019.
REQ-022 Ring period is N enabled steps; Johnson period is 2N enabled steps. Both directions trace the same cycle in reverse.
REQ-023 The step latency is one clock: q reflects the new state in the cycle after the enabled edge.

Reset
REQ-024 While rst = 0: q = 0...01 and wrap = 0, asynchronously and regardless of clk. 0...01 is legal in both modes.
REQ-025 Reset asserted mid-count discards the current state immediately. The first enabled edge after rst deasserts steps from 0...01.
REQ-026 illegal follows q and mode combinationally during reset: it is 0 in both modes.

Structure
REQ-027 A shared package holds:
- the mode typedef (MODE_RING = 0, MODE_JOHNSON = 1);
- the direction typedef (DIR_UP = 0, DIR_DOWN = 1).
REQ-028 Legality detection lives in one combinational sub-module, ring_code_check. It takes parameter N and ports code and mode, and drives output illegal.
REQ-029 The state register and next-state mux remain in multimode_ring_counter. An elaboration-time check rejects N < 2.

Verification (N = 4)
REQ-030 Reset, then mode = 0, dir = 0, en = 1 for 4 cycles -> q = 0010, 0100, 1000, 0001; wrap = 1 only with the final 0001.
REQ-031 Load 0000 in mode = 1, then en = 1 for 8 cycles -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; wrap = 1 only with the final 0000.
REQ-032 From reset, mode = 0, dir = 1, en = 1 for 2 cycles -> q = 1000, 0100; wrap = 0 throughout.
REQ-033 Mode = 0, load = 1 with load_val = 0101 -> q = 0101 and illegal = 1. Next edge with en = 1 -> q = 0001, illegal = 0, wrap = 0.
REQ-034 en = 0 for 3 cycles -> q holds. load = 1 with en = 0 and load_val = 0100 -> q = 0100.
REQ-035 rst driven low mid-cycle at q = 0100 -> q = 0001 and wrap = 0 before the next clk edge. Stepping resumes after release.
